// File: rtl/game_flow_controller_if.sv
// Signal bundle between the game flow controller, the per-lane compare logic and the display path.
// The controller side uses the master modport; the lanes/display side uses slave.
interface game_flow_controller_if #(
  parameter int LANES   = 3,
  parameter int SCORE_W = 8
);
  logic               start_button;
  logic [LANES-1:0]   game_over;
  logic [LANES-1:0]   correct;
  logic               reset_signal;
  logic               point_pulse;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] best_score;
  logic [3:0]         lives;
  logic [2:0]         state;
  logic               new_best;

  modport master (
    input  start_button, game_over, correct,
    output reset_signal, point_pulse, score, best_score, lives, state, new_best
  );

  modport slave (
    output start_button, game_over, correct,
    input  reset_signal, point_pulse, score, best_score, lives, state, new_best
  );
endinterface

// File: rtl/game_flow_controller.sv
// Round sequencer for LANES puzzle lanes: saturating score, lives counter, optional best score.
// Define BEST_SCORE_EN to build the best-score register and new_best pulse; otherwise both read 0.
module game_flow_controller #(
  parameter int LANES   = 3,
  parameter int SCORE_W = 8,
  parameter int LIVES   = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  game_flow_controller_if.master bus
);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_RUNNING = 3'd1,
    ST_POINT   = 3'd2,
    ST_MISS    = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
  localparam logic [SCORE_W+3:0] SCORE_MAX  = {4'b0000, {SCORE_W{1'b1}}};

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;

  logic               miss_any;
  logic               hit_any;
  logic [3:0]         hits;
  logic [SCORE_W+3:0] score_sum;

  assign miss_any = |bus.game_over;
  assign hit_any  = |bus.correct;

  always_comb begin
    hits = '0;
    for (int i = 0; i < LANES; i++) begin
      hits = hits + 4'(bus.correct[i]);
    end
  end

  // Widened by 4 bits so up to 8 simultaneous hits cannot wrap before saturation.
  assign score_sum = {4'b0000, score_q} + {{SCORE_W{1'b0}}, hits};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    case (state_q)
      ST_START: begin
        state_d = ST_RUNNING;
        score_d = '0;
        lives_d = LIVES_INIT;
      end
      ST_RUNNING: begin
        if (miss_any) begin
          state_d = ST_MISS;
          lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
        end else if (hit_any) begin
          state_d = ST_POINT;
          score_d = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        end
      end
      ST_POINT: state_d = ST_RUNNING;
      ST_MISS:  state_d = (lives_q == 4'd0) ? ST_OVER : ST_RUNNING;
      ST_OVER:  if (bus.start_button) state_d = ST_START;
      default:  state_d = ST_START;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) begin
      state_q <= ST_START;
      score_q <= '0;
      lives_q <= LIVES_INIT;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
    end
  end

`ifdef BEST_SCORE_EN
  logic               enter_over;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               new_best_q, new_best_d;

  assign enter_over = (state_q == ST_MISS) && (lives_q == 4'd0);

  always_comb begin
    best_d     = best_q;
    new_best_d = 1'b0;
    if (enter_over && (score_q > best_q)) begin
      best_d     = score_q;
      new_best_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      best_q     <= '0;
      new_best_q <= 1'b0;
    end else begin
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  assign bus.best_score = best_q;
  assign bus.new_best   = new_best_q;
`else
  assign bus.best_score = '0;
  assign bus.new_best   = 1'b0;
`endif

  // Strobes decode the state register only, so no input reaches them combinationally.
  assign bus.reset_signal = (state_q != ST_RUNNING);
  assign bus.point_pulse  = (state_q == ST_POINT);
  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: a cycle model pushes expected outputs to a
// scoreboard queue as each stimulus cycle is driven; entries are popped and compared after the edge.
module tb_game_flow_controller;

  localparam int LANES   = 3;
  localparam int SCORE_W = 4;
  localparam int LIVES   = 3;
  localparam int SMAX    = (1 << SCORE_W) - 1;
`ifdef BEST_SCORE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  typedef struct {
    int state;
    int score;
    int lives;
    int best;
    int new_best;
    int reset_signal;
    int point_pulse;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  int m_state, m_score, m_lives, m_best;

  game_flow_controller_if #(.LANES(LANES), .SCORE_W(SCORE_W)) bus ();

  game_flow_controller #(.LANES(LANES), .SCORE_W(SCORE_W), .LIVES(LIVES)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, ".state"},        32'(bus.state),        e.state);
    check({tag, ".score"},        32'(bus.score),        e.score);
    check({tag, ".lives"},        32'(bus.lives),        e.lives);
    check({tag, ".best_score"},   32'(bus.best_score),   e.best);
    check({tag, ".new_best"},     32'(bus.new_best),     e.new_best);
    check({tag, ".reset_signal"}, 32'(bus.reset_signal), e.reset_signal);
    check({tag, ".point_pulse"},  32'(bus.point_pulse),  e.point_pulse);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_score = 0;
    m_lives = LIVES;
    m_best  = 0;
  endtask

  function automatic exp_t reset_expect();
    exp_t e;
    e.state = 0; e.score = 0; e.lives = LIVES; e.best = 0;
    e.new_best = 0; e.reset_signal = 1; e.point_pulse = 0;
    return e;
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, then compare after the edge.
  task automatic step(input string tag, input logic sb, input logic [2:0] go, input logic [2:0] cor);
    exp_t e;
    int   ns, nsc, nl, nb, nnb;
    bus.start_button = sb;
    bus.game_over    = go;
    bus.correct      = cor;
    ns = m_state; nsc = m_score; nl = m_lives; nb = m_best; nnb = 0;
    case (m_state)
      0: begin ns = 1; nsc = 0; nl = LIVES; end
      1: begin
        if (go != 3'b000) begin
          ns = 3;
          if (nl > 0) nl = nl - 1;
        end else if (cor != 3'b000) begin
          ns  = 2;
          nsc = m_score + $countones(cor);
          if (nsc > SMAX) nsc = SMAX;
        end
      end
      2: ns = 1;
      3: begin
        if (m_lives == 0) begin
          ns = 4;
          if (BEST_EN && (m_score > m_best)) begin
            nb  = m_score;
            nnb = 1;
          end
        end else begin
          ns = 1;
        end
      end
      4: if (sb) ns = 0;
      default: ns = 0;
    endcase
    m_state = ns; m_score = nsc; m_lives = nl; m_best = nb;
    e.state = ns; e.score = nsc; e.lives = nl; e.best = nb; e.new_best = nnb;
    e.reset_signal = (ns != 1) ? 1 : 0;
    e.point_pulse  = (ns == 2) ? 1 : 0;
    sb_q.push_back(e);

    @(posedge clock);
    #1;
    bus.start_button = 1'b0;
    bus.game_over    = '0;
    bus.correct      = '0;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      compare_outputs(tag, sb_q.pop_front());
    end
  endtask

  task automatic hit(input string tag, input logic [2:0] cor);
    step(tag, 1'b0, 3'b000, cor);
    step({tag, "_ret"}, 1'b0, 3'b000, 3'b000);
  endtask

  task automatic miss(input string tag, input logic [2:0] go);
    step(tag, 1'b0, go, 3'b000);
    step({tag, "_ret"}, 1'b0, 3'b000, 3'b000);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.start_button = 1'b0;
    bus.game_over    = '0;
    bus.correct      = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_outputs("reset", reset_expect());
    @(negedge clock);
    reset_n = 1'b1;

    step("boot", 1'b0, 3'b000, 3'b000);
    step("idle", 1'b0, 3'b000, 3'b000);

    hit("hit101", 3'b101);
    step("miss_and_hit", 1'b0, 3'b010, 3'b001);
    step("miss_ret", 1'b0, 3'b000, 3'b000);
    step("start_ignored", 1'b1, 3'b000, 3'b000);

    hit("hitA", 3'b001);
    hit("hitB", 3'b001);
    hit("hitC", 3'b001);
    step("miss1", 1'b0, 3'b001, 3'b000);
    step("miss1_in_miss", 1'b0, 3'b000, 3'b111);
    step("miss2", 1'b0, 3'b100, 3'b000);
    step("enter_over", 1'b0, 3'b000, 3'b000);
    step("over_hold", 1'b0, 3'b000, 3'b000);
    step("over_inputs", 1'b0, 3'b111, 3'b111);
    step("restart", 1'b1, 3'b000, 3'b000);
    step("restart_run", 1'b0, 3'b000, 3'b000);

    hit("g2_hit111", 3'b111);
    miss("g2_miss1", 3'b001);
    miss("g2_miss2", 3'b010);
    step("g2_miss3", 1'b0, 3'b100, 3'b000);
    step("g2_over", 1'b0, 3'b000, 3'b000);
    step("g2_over_hold", 1'b0, 3'b000, 3'b000);
    step("g2_restart", 1'b1, 3'b000, 3'b000);
    step("g2_run", 1'b0, 3'b000, 3'b000);

    step("g3_hit111", 1'b0, 3'b000, 3'b111);
    step("g3_point_inputs", 1'b0, 3'b111, 3'b111);

    // Asynchronous reset mid-cycle: outputs must return to reset values without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_outputs("mid_reset", reset_expect());
    @(negedge clock);
    reset_n = 1'b1;
    step("post_reset_boot", 1'b0, 3'b000, 3'b000);

    for (int i = 0; i < 4; i++) hit("sat_fill", 3'b111);
    hit("sat_to14", 3'b011);
    hit("sat_to15", 3'b111);
    hit("sat_at_max", 3'b111);
    hit("sat_one_more", 3'b001);

    if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Parametrised successor to the single-puzzle game state machine; sequences rounds for LANES independent puzzle lanes.
- Tracks a saturating multi-point score, a lives counter and a best score.
- Drives the lane-reset strobe and a score-event pulse to the display and puzzle generators.
- Sits between the per-lane compare logic (hit/miss flags) and the seven-segment/LED display path.

Parameters:
- LANES, 3, number of puzzle lanes (1..8).
- SCORE_W, 8, score and best-score width in bits.
- LIVES, 3, misses allowed before game over (1..15).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- start_button  input  1  synchronised, one-cycle pulse; leaves OVER.
- game_over  input  LANES  per-lane miss flag (lane timed out / wrong answer).
- correct  input  LANES  per-lane hit flag.
- reset_signal  output  1  lane/puzzle reload strobe.
- point_pulse  output  1  one-cycle pulse when score changes.
- score  output  SCORE_W  current score.
- best_score  output  SCORE_W  highest final score since reset.
- lives  output  4  remaining lives.
- state  output  3  current state encoding.

Behaviour:
- States and encoding: START=0, RUNNING=1, POINT=2, MISS=3, OVER=4. Unused codes go to START on the next clock.
- Reset (reset_n low, asynchronous):
  - state=START, score=0, best_score=0, lives=LIVES, point_pulse=0.
  - reset_signal=1, because START decodes it.
- Definitions: miss_any = OR(game_over); hit_any = OR(correct); hits = popcount(correct).
- START:
  - reset_signal=1; score cleared to 0; lives loaded to LIVES.
  - Next state is RUNNING unconditionally. Inputs are ignored.
- RUNNING, evaluated in priority order:
  - miss_any=1 → MISS. Miss has priority; a simultaneous correct is discarded and the score is not changed.
  - else hit_any=1 → POINT. On the same edge, score <= min(score+hits, 2^SCORE_W-1), computed in SCORE_W+4 bits then saturated.
  - else stay in RUNNING.
- POINT:
  - point_pulse=1 and reset_signal=1 for exactly this cycle; hit lanes reload.
  - Next state is RUNNING. Inputs are ignored.
- Lives update: lives decrements by 1 on the edge entering MISS; it never goes below 0.
- MISS:
  - reset_signal=1.
  - lives==0 → OVER; otherwise → RUNNING. Score is kept.
- OVER:
  - reset_signal held 1; score frozen.
  - start_button=1 → START; otherwise stay in OVER.
  - On the edge entering OVER: best_score updates (see optional feature).
- Output timing: reset_signal and point_pulse are combinational decodes of state only (no input paths). score, lives and best_score are registered.
- Latency: hit sampled in RUNNING → score visible 1 cycle later, together with point_pulse. Round-trip RUNNING→POINT→RUNNING takes 2 cycles.
- Boundaries:
  - score already at max plus more hits: stays at max; point_pulse still fires.
  - All lanes correct in one cycle: +LANES.
  - start_button outside OVER: ignored.
  - reset_n asserted mid-operation: immediate return to reset values. best_score is cleared too (no retention across reset).

Optional Feature:
- Macro: BEST_SCORE_EN.
- Defined:
  - On entry to OVER, best_score <= score if score > best_score.
  - new_best output (1 bit) pulses high for the first OVER cycle when an update occurred.
- Undefined:
  - best_score is tied to 0; the new_best port is still present and tied to 0.
  - No compare or register logic is synthesised.

Test Plan:
- Reset release, no inputs → state 0 then 1. Score 0, lives 3, reset_signal 1 in cycle 0, 0 from cycle 1.
- RUNNING, correct=3'b101 for one cycle → state 2 next cycle; score 2, point_pulse=1 one cycle; back to state 1.
- RUNNING, game_over=3'b010 with correct=3'b001 same cycle → state 3; score unchanged; lives 3→2; then state 1.
- Three separate misses → lives 2,1,0; state 4 after third MISS; start_button pulse → state 0, score 0, lives 3.
- SCORE_W=4, score=14, correct=3'b111 → score 15 (saturated); point_pulse=1.
- BEST_SCORE_EN: game ends at score 5 → best_score=5, new_best=1 one cycle. Next game ends at 3 → best_score stays 5, new_best=0.
